// File: rtl/ddr_package.sv
// Shared types and default timing for the DDR refresh/MRS scheduler.
package ddr_package;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RW      = 3'd2,
        DRAIN   = 3'd3,
        REFRESH = 3'd4,
        UPDATE  = 3'd5
    } ctrl_sched_state_t;

    localparam int DEF_TREFI        = 1560;
    localparam int DEF_TRFC         = 260;
    localparam int DEF_TMOD         = 24;
    localparam int DEF_MAX_POSTPONE = 8;
    localparam int DEF_MRS_WIDTH    = 14;

endpackage

// File: rtl/ddr_ctrl_sched_if.sv
// Handshake/status bundle between the scheduler (slave) and its client (master).
interface ddr_ctrl_sched_if
    import ddr_package::*;
#(
    parameter int MRS_WIDTH = DEF_MRS_WIDTH
) ();

    logic                 config_done;
    logic                 rw_idle;
    logic                 mrs_update;
    logic [1:0]           mrs_bl;
    logic [MRS_WIDTH-1:0] mr0;
    logic                 rw_proc;
    logic                 dev_busy;
    logic                 refresh_rdy;
    logic                 mrs_update_rdy;
    logic [MRS_WIDTH-1:0] mrs_update_cmd;
    logic [3:0]           refresh_owed;
    logic                 refresh_urgent;

    modport master (
        output config_done, rw_idle, mrs_update, mrs_bl, mr0,
        input  rw_proc, dev_busy, refresh_rdy, mrs_update_rdy,
               mrs_update_cmd, refresh_owed, refresh_urgent
    );

    modport slave (
        input  config_done, rw_idle, mrs_update, mrs_bl, mr0,
        output rw_proc, dev_busy, refresh_rdy, mrs_update_rdy,
               mrs_update_cmd, refresh_owed, refresh_urgent
    );

endinterface

// File: rtl/ddr_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module ddr_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clock_t,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             done_r;

    // Next count: load wins, otherwise decrement and stop at zero.
    always_comb begin
        count_nxt_s = count_r;
        if (load) begin
            count_nxt_s = load_val;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_nxt_s = count_r - WIDTH'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count and done registers.
    always_ff @(posedge clock_t) begin
        if (!reset_n) begin
            count_r <= {WIDTH{1'b0}};
            done_r  <= 1'b1;
        end else begin
            count_r <= count_nxt_s;
            done_r  <= (count_nxt_s == {WIDTH{1'b0}});
        end
    end

    assign done = done_r;

endmodule

// File: rtl/ddr_ctrl_sched.sv
// Refresh / MR0 burst-length update scheduler: tracks owed refreshes, postpones
// them while the read/write engine is busy and serialises REFRESH and UPDATE.
module ddr_ctrl_sched
    import ddr_package::*;
#(
    parameter int TREFI        = DEF_TREFI,
    parameter int TRFC         = DEF_TRFC,
    parameter int TMOD         = DEF_TMOD,
    parameter int MAX_POSTPONE = DEF_MAX_POSTPONE,
    parameter int MRS_WIDTH    = DEF_MRS_WIDTH
) (
    input  logic            clock_t,
    input  logic            reset_n,
    ddr_ctrl_sched_if.slave bus
);

    localparam int CNT_W   = $clog2(TREFI + 1);
    localparam int TMR_MAX = (TRFC > TMOD) ? TRFC : TMOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] IVL_LAST = CNT_W'(TREFI - 1);
    localparam logic [3:0]       OWED_MAX = 4'(MAX_POSTPONE);
    localparam logic [TMR_W-1:0] REF_LOAD = TMR_W'(TRFC - 1);
    localparam logic [TMR_W-1:0] UPD_LOAD = TMR_W'(TMOD - 1);

    ctrl_sched_state_t    state_r, state_nxt_s;
    logic [CNT_W-1:0]     ivl_r, ivl_nxt_s;
    logic [3:0]           owed_r, owed_nxt_s;
    logic                 pending_r, pending_nxt_s;
    logic [MRS_WIDTH-1:0] cmd_r, cmd_nxt_s;
    logic                 rw_proc_r, dev_busy_r, refresh_rdy_r, mrs_rdy_r, urgent_r;
    logic                 active_s, wrap_s, refresh_end_s, req_accept_s, service_due_s;
    logic                 ref_entry_s, upd_entry_s, tmr_load_s, tmr_done_s;
    logic [TMR_W-1:0]     tmr_val_s;

    function automatic logic [MRS_WIDTH-1:0] merge_bl(input logic [MRS_WIDTH-1:0] mr,
                                                      input logic [1:0]           bl);
        logic [MRS_WIDTH-1:0] bl_mask;
        bl_mask = {{(MRS_WIDTH-2){1'b0}}, 2'b11};
        return (mr & ~bl_mask) | {{(MRS_WIDTH-2){1'b0}}, bl};
    endfunction

    // Refresh always beats a pending MR0 update.
    function automatic ctrl_sched_state_t service_pick(input logic [3:0] owed, input logic pend);
        if (owed != 4'd0) begin
            return REFRESH;
        end else if (pend) begin
            return UPDATE;
        end else begin
            return RW;
        end
    endfunction

    assign active_s      = (state_r != IDLE) && (state_r != INIT);
    assign wrap_s        = active_s && (ivl_r == IVL_LAST);
    assign refresh_end_s = (state_r == REFRESH) && tmr_done_s;
    assign req_accept_s  = active_s && bus.mrs_update;
    assign service_due_s = urgent_r || pending_r || ((owed_r != 4'd0) && bus.rw_idle);
    assign ref_entry_s   = (state_nxt_s == REFRESH) && (state_r != REFRESH);
    assign upd_entry_s   = (state_nxt_s == UPDATE) && (state_r != UPDATE);
    assign tmr_load_s    = ref_entry_s || upd_entry_s;
    assign tmr_val_s     = ref_entry_s ? REF_LOAD : UPD_LOAD;

    // Next-state logic; an already idle engine needs no DRAIN cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: state_nxt_s = INIT;
            INIT: begin
                if (bus.config_done) state_nxt_s = RW;
                else                 state_nxt_s = INIT;
            end
            RW: begin
                if (!service_due_s)    state_nxt_s = RW;
                else if (bus.rw_idle)  state_nxt_s = service_pick(owed_r, pending_r);
                else                   state_nxt_s = DRAIN;
            end
            DRAIN: begin
                if (bus.rw_idle) state_nxt_s = service_pick(owed_r, pending_r);
                else             state_nxt_s = DRAIN;
            end
            REFRESH, UPDATE: begin
                if (tmr_done_s) state_nxt_s = RW;
                else            state_nxt_s = state_r;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Interval counter, owed-refresh count and sticky MR0 update request.
    always_comb begin
        ivl_nxt_s     = ivl_r;
        owed_nxt_s    = owed_r;
        pending_nxt_s = pending_r;
        cmd_nxt_s     = cmd_r;
        if (!active_s || wrap_s) ivl_nxt_s = {CNT_W{1'b0}};
        else                     ivl_nxt_s = ivl_r + CNT_W'(1);
        case ({wrap_s, refresh_end_s})
            2'b10: begin
                if (owed_r != OWED_MAX) owed_nxt_s = owed_r + 4'd1;
                else                    owed_nxt_s = owed_r;
            end
            2'b01: begin
                if (owed_r != 4'd0) owed_nxt_s = owed_r - 4'd1;
                else                owed_nxt_s = owed_r;
            end
            default: owed_nxt_s = owed_r;
        endcase
        // A request landing on the UPDATE entry cycle is kept, not dropped.
        if (req_accept_s) begin
            pending_nxt_s = 1'b1;
            cmd_nxt_s     = merge_bl(bus.mr0, bus.mrs_bl);
        end else if (upd_entry_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock_t) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            ivl_r         <= {CNT_W{1'b0}};
            owed_r        <= 4'd0;
            pending_r     <= 1'b0;
            cmd_r         <= {MRS_WIDTH{1'b0}};
            rw_proc_r     <= 1'b0;
            dev_busy_r    <= 1'b1;
            refresh_rdy_r <= 1'b0;
            mrs_rdy_r     <= 1'b0;
            urgent_r      <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            ivl_r         <= ivl_nxt_s;
            owed_r        <= owed_nxt_s;
            pending_r     <= pending_nxt_s;
            cmd_r         <= cmd_nxt_s;
            rw_proc_r     <= (state_nxt_s == RW);
            dev_busy_r    <= (state_nxt_s != RW);
            refresh_rdy_r <= ref_entry_s;
            mrs_rdy_r     <= upd_entry_s;
            urgent_r      <= (owed_nxt_s == OWED_MAX);
        end
    end

    ddr_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clock_t  (clock_t),
        .reset_n  (reset_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .done     (tmr_done_s)
    );

    assign bus.rw_proc        = rw_proc_r;
    assign bus.dev_busy       = dev_busy_r;
    assign bus.refresh_rdy    = refresh_rdy_r;
    assign bus.mrs_update_rdy = mrs_rdy_r;
    assign bus.mrs_update_cmd = cmd_r;
    assign bus.refresh_owed   = owed_r;
    assign bus.refresh_urgent = urgent_r;

endmodule
